// File: rtl/mul_share_arbiter.sv
// -----------------------------------------------------------------------------
// mul_share_arbiter
//   Shares one pipelined Booth multiplier among NUM_REQ requesters.
//   A round-robin arbiter issues at most one operation per cycle. The winner's
//   ID travels through a tag pipe that matches the multiplier latency. Results
//   land in a credit-protected response FIFO, which drains with valid/ready.
//
// Ports
//   clk_i, rstn_i      clock, asynchronous active-low reset
//   req_valid_i        per-requester request valid
//   req_ready_o        per-requester accept (one-hot or zero)
//   req_sign_i         per-requester signedness of A (1 = signed)
//   req_a_i, req_b_i   packed operands; requester r sits at [r*W +: W]
//   mul_valid_o        operation issue to the multiplier
//   mul_sign_o         signedness of A, to the multiplier
//   mul_a_o, mul_b_o   operands, to the multiplier
//   mul_valid_i        result valid, from the multiplier
//   mul_result_i       product, from the multiplier
//   rsp_valid_o        response FIFO head valid
//   rsp_ready_i        response consumer ready
//   rsp_id_o           requester ID of the head entry
//   rsp_result_o       signed product of the head entry
//   err_o              sticky error: the multiplier result did not match the tag pipe
// -----------------------------------------------------------------------------
module mul_share_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int A_WIDTH    = 12,
    parameter int B_WIDTH    = 23,
    parameter int PROD_WIDTH = A_WIDTH + B_WIDTH,
    parameter int MUL_LAT    = 1,
    parameter int RSP_DEPTH  = 4,
    parameter int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                         clk_i,
    input  logic                         rstn_i,
    input  logic [NUM_REQ-1:0]           req_valid_i,
    output logic [NUM_REQ-1:0]           req_ready_o,
    input  logic [NUM_REQ-1:0]           req_sign_i,
    input  logic [NUM_REQ*A_WIDTH-1:0]   req_a_i,
    input  logic [NUM_REQ*B_WIDTH-1:0]   req_b_i,
    output logic                         mul_valid_o,
    output logic                         mul_sign_o,
    output logic [A_WIDTH-1:0]           mul_a_o,
    output logic [B_WIDTH-1:0]           mul_b_o,
    input  logic                         mul_valid_i,
    input  logic [PROD_WIDTH-1:0]        mul_result_i,
    output logic                         rsp_valid_o,
    input  logic                         rsp_ready_i,
    output logic [ID_W-1:0]              rsp_id_o,
    output logic [PROD_WIDTH-1:0]        rsp_result_o,
    output logic                         err_o
);

    localparam int CNT_W = $clog2(RSP_DEPTH + 1);
    localparam int PTR_W = $clog2(RSP_DEPTH);

    // Round-robin successor of a requester index.
    function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
        logic [ID_W-1:0] nxt;
        if (id == ID_W'(NUM_REQ - 1)) begin
            nxt = {ID_W{1'b0}};
        end else begin
            nxt = id + ID_W'(1);
        end
        return nxt;
    endfunction

    logic [ID_W-1:0]        rr_ptr_r;
    logic [CNT_W-1:0]       outstanding_r;
    logic                   found_s;
    logic [ID_W-1:0]        winner_s;
    logic [ID_W-1:0]        slot_s;
    logic                   credit_ok_s;
    logic                   issue_s;
    logic                   pop_s;
    logic                   push_s;

    logic                   tag_vld_r [MUL_LAT];
    logic [ID_W-1:0]        tag_id_r  [MUL_LAT];

    logic [ID_W-1:0]        id_mem_r  [RSP_DEPTH];
    logic [PROD_WIDTH-1:0]  res_mem_r [RSP_DEPTH];
    logic [PTR_W:0]         wr_ptr_r;
    logic [PTR_W:0]         rd_ptr_r;
    logic                   fifo_empty_s;
    logic                   fifo_full_s;
    logic                   err_r;

    // Round-robin scan: first valid requester at or above the pointer, with wrap.
    always_comb begin
        int idx;
        found_s  = 1'b0;
        winner_s = rr_ptr_r;
        idx      = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(rr_ptr_r) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end else begin
                idx = idx;
            end
            if (!found_s && req_valid_i[idx]) begin
                found_s  = 1'b1;
                winner_s = ID_W'(idx);
            end else begin
                found_s  = found_s;
            end
        end
    end

    // Credits are judged on the registered count only, so a pop in this
    // cycle frees its slot for the next cycle, never this one. The reset
    // term holds every combinational output at zero while reset is asserted.
    assign credit_ok_s = (outstanding_r < CNT_W'(RSP_DEPTH));
    assign issue_s     = rstn_i & credit_ok_s & found_s;
    assign slot_s      = found_s ? winner_s : rr_ptr_r;

    // Issue-side outputs: one-hot grant and the selected operands.
    always_comb begin
        req_ready_o = {NUM_REQ{1'b0}};
        mul_valid_o = 1'b0;
        mul_sign_o  = 1'b0;
        mul_a_o     = {A_WIDTH{1'b0}};
        mul_b_o     = {B_WIDTH{1'b0}};
        if (rstn_i) begin
            mul_sign_o = req_sign_i[slot_s];
            mul_a_o    = req_a_i[int'(slot_s)*A_WIDTH +: A_WIDTH];
            mul_b_o    = req_b_i[int'(slot_s)*B_WIDTH +: B_WIDTH];
        end else begin
            mul_sign_o = 1'b0;
        end
        if (issue_s) begin
            req_ready_o = {{(NUM_REQ-1){1'b0}}, 1'b1} << winner_s;
            mul_valid_o = 1'b1;
        end else begin
            mul_valid_o = 1'b0;
        end
    end

    // Round-robin pointer: moves past the winner on issue, holds otherwise.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rr_ptr_r <= {ID_W{1'b0}};
        end else if (issue_s) begin
            rr_ptr_r <= next_id(winner_s);
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

    // Tag pipe: the multiplier cannot stall, so the pipe advances every cycle.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int s = 0; s < MUL_LAT; s++) begin
                tag_vld_r[s] <= 1'b0;
                tag_id_r[s]  <= {ID_W{1'b0}};
            end
        end else begin
            tag_vld_r[0] <= issue_s;
            tag_id_r[0]  <= winner_s;
            for (int s = 1; s < MUL_LAT; s++) begin
                tag_vld_r[s] <= tag_vld_r[s-1];
                tag_id_r[s]  <= tag_id_r[s-1];
            end
        end
    end

    // FIFO status from the wrap-bit pointers.
    assign fifo_empty_s = (wr_ptr_r == rd_ptr_r);
    assign fifo_full_s  = (wr_ptr_r == {~rd_ptr_r[PTR_W], rd_ptr_r[PTR_W-1:0]});
    assign pop_s        = (~fifo_empty_s) & rsp_ready_i;
    // Credits make overflow impossible in normal operation. The guard only
    // matters after a protocol error, which err_o already reports.
    assign push_s       = mul_valid_i & (~fifo_full_s | pop_s);

    // Response FIFO storage and pointers.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr_r <= {(PTR_W+1){1'b0}};
            rd_ptr_r <= {(PTR_W+1){1'b0}};
            for (int e = 0; e < RSP_DEPTH; e++) begin
                id_mem_r[e]  <= {ID_W{1'b0}};
                res_mem_r[e] <= {PROD_WIDTH{1'b0}};
            end
        end else begin
            if (push_s) begin
                id_mem_r[wr_ptr_r[PTR_W-1:0]]  <= tag_id_r[MUL_LAT-1];
                res_mem_r[wr_ptr_r[PTR_W-1:0]] <= mul_result_i;
                wr_ptr_r <= wr_ptr_r + (PTR_W+1)'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + (PTR_W+1)'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
        end
    end

    // FIFO head. The fields read as zero when the FIFO is empty.
    always_comb begin
        rsp_valid_o  = ~fifo_empty_s;
        rsp_id_o     = {ID_W{1'b0}};
        rsp_result_o = {PROD_WIDTH{1'b0}};
        if (!fifo_empty_s) begin
            rsp_id_o     = id_mem_r[rd_ptr_r[PTR_W-1:0]];
            rsp_result_o = res_mem_r[rd_ptr_r[PTR_W-1:0]];
        end else begin
            rsp_id_o     = {ID_W{1'b0}};
        end
    end

    // Outstanding counter: issues in flight plus entries still buffered.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            outstanding_r <= {CNT_W{1'b0}};
        end else begin
            case ({issue_s, pop_s})
                2'b10: outstanding_r <= outstanding_r + CNT_W'(1);
                2'b01: begin
                    if (outstanding_r != {CNT_W{1'b0}}) begin
                        outstanding_r <= outstanding_r - CNT_W'(1);
                    end else begin
                        outstanding_r <= outstanding_r;
                    end
                end
                default: outstanding_r <= outstanding_r;
            endcase
        end
    end

    // Sticky error: a result arrived without a matching tag, or a tag with no result.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            err_r <= 1'b0;
        end else if (mul_valid_i != tag_vld_r[MUL_LAT-1]) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    assign err_o = err_r;

endmodule

// File: tb/tb_mul_share_arbiter.sv
module tb_mul_share_arbiter;

    localparam int N     = 4;
    localparam int AW    = 12;
    localparam int BW    = 23;
    localparam int PW    = AW + BW;
    localparam int IW    = 2;
    localparam int DEPTH = 4;

    logic              clk = 1'b0;
    logic              rstn;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N-1:0]      req_sign;
    logic [N*AW-1:0]   req_a;
    logic [N*BW-1:0]   req_b;
    logic              mul_valid_o;
    logic              mul_sign_o;
    logic [AW-1:0]     mul_a_o;
    logic [BW-1:0]     mul_b_o;
    logic              mul_valid_i;
    logic [PW-1:0]     mul_result_i;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IW-1:0]     rsp_id;
    logic [PW-1:0]     rsp_result;
    logic              err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mul_share_arbiter dut (
        .clk_i        (clk),
        .rstn_i       (rstn),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_sign_i   (req_sign),
        .req_a_i      (req_a),
        .req_b_i      (req_b),
        .mul_valid_o  (mul_valid_o),
        .mul_sign_o   (mul_sign_o),
        .mul_a_o      (mul_a_o),
        .mul_b_o      (mul_b_o),
        .mul_valid_i  (mul_valid_i),
        .mul_result_i (mul_result_i),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_id_o     (rsp_id),
        .rsp_result_o (rsp_result),
        .err_o        (err)
    );

    // Signed product: A sign- or zero-extended, B always signed, truncated to PW bits.
    function automatic logic [PW-1:0] ref_product(input logic s, input logic [AW-1:0] a,
                                                  input logic [BW-1:0] b);
        longint av;
        longint bv;
        longint p;
        av = s ? {{(64-AW){a[AW-1]}}, a} : {{(64-AW){1'b0}}, a};
        bv = {{(64-BW){b[BW-1]}}, b};
        p  = av * bv;
        return p[PW-1:0];
    endfunction

    // One-cycle multiplier model, on the same reset as the DUT.
    logic          mv_r;
    logic [PW-1:0] mr_r;
    logic          inj;
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mv_r <= 1'b0;
            mr_r <= '0;
        end else begin
            mv_r <= mul_valid_o;
            mr_r <= ref_product(mul_sign_o, mul_a_o, mul_b_o);
        end
    end
    assign mul_valid_i  = mv_r | inj;
    assign mul_result_i = mr_r;

    // Scoreboard: expected responses with their accept cycle.
    typedef struct {
        int            id;
        logic [PW-1:0] p;
        int            cyc;
    } exp_t;
    exp_t q[$];
    int   m_ptr  = 0;
    int   m_out  = 0;
    int   cyc    = 0;
    bit   mon_en = 1'b0;

    // Reference model checked every cycle: round-robin winner, credit limit, latency, ordering.
    always @(negedge clk) begin : monitor
        int           w;
        int           k;
        logic [N-1:0] one;
        logic [N-1:0] exp_rdy;
        bit           exp_rv;
        cyc = cyc + 1;
        if (mon_en && rstn) begin
            w   = -1;
            one = 1;
            if (m_out < DEPTH) begin
                for (int i = 0; i < N; i++) begin
                    k = (m_ptr + i) % N;
                    if (w < 0 && req_valid[k]) w = k;
                end
            end
            exp_rdy = (w >= 0) ? (one << w) : '0;
            total++;
            if (req_ready !== exp_rdy) begin
                bad++;
                $display("FAIL grant: got %b want %b at cycle %0d", req_ready, exp_rdy, cyc);
            end
            total++;
            if (mul_valid_o !== (w >= 0)) begin
                bad++;
                $display("FAIL mul_valid: got %b want %b at cycle %0d", mul_valid_o, (w >= 0), cyc);
            end
            exp_rv = (q.size() > 0) && (q[0].cyc <= cyc - 2);
            total++;
            if (rsp_valid !== exp_rv) begin
                bad++;
                $display("FAIL rsp_valid: got %b want %b at cycle %0d", rsp_valid, exp_rv, cyc);
            end
            if (exp_rv) begin
                total++;
                if (rsp_id !== IW'(q[0].id) || rsp_result !== q[0].p) begin
                    bad++;
                    $display("FAIL rsp_head: got id=%0d res=%h want id=%0d res=%h", rsp_id, rsp_result, q[0].id, q[0].p);
                end
                if (rsp_ready) begin
                    void'(q.pop_front());
                    m_out--;
                end
            end
            if (w >= 0) begin
                total++;
                if ({mul_sign_o, mul_a_o, mul_b_o} !== {req_sign[w], req_a[w*AW +: AW], req_b[w*BW +: BW]}) begin
                    bad++;
                    $display("FAIL operands: got %b/%h/%h for requester %0d", mul_sign_o, mul_a_o, mul_b_o, w);
                end
                q.push_back('{w, ref_product(req_sign[w], req_a[w*AW +: AW], req_b[w*BW +: BW]), cyc});
                m_ptr = (w + 1) % N;
                m_out++;
            end
            total++;
            if (err !== 1'b0) begin
                bad++;
                $display("FAIL err_idle: got %b want 0 at cycle %0d", err, cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_ops();
        for (int r = 0; r < N; r++) begin
            req_a[r*AW +: AW] = AW'($urandom);
            req_b[r*BW +: BW] = BW'($urandom);
        end
        req_sign = N'($urandom);
    endtask

    task automatic model_clear();
        q.delete();
        m_ptr = 0;
        m_out = 0;
    endtask

    task automatic drain(input int cycles);
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (cycles) tick();
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d responses still expected", q.size());
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0; inj = 1'b0; req_valid = '0; req_sign = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
        #12;
        total++;
        if ({req_ready, mul_valid_o, rsp_valid, err, rsp_id, rsp_result} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: ready=%b mv=%b rv=%b err=%b id=%0d res=%h",
                     req_ready, mul_valid_o, rsp_valid, err, rsp_id, rsp_result);
        end
        tick();
        rstn = 1'b1;
        model_clear();
        mon_en = 1'b1;
    endtask

    task automatic test_single();
        logic          s_tab [3] = '{1'b1, 1'b0, 1'b1};
        logic [AW-1:0] a_tab [3] = '{12'hFFF, 12'hFFF, 12'h800};
        logic [BW-1:0] b_tab [3] = '{23'd5, 23'd5, 23'h7FFFFF};
        logic [PW-1:0] e_tab [3] = '{35'h7_FFFF_FFFB, 35'h0_0000_4FFB, 35'h0_0000_0800};
        rsp_ready = 1'b1;
        for (int t = 0; t < 3; t++) begin
            tick();
            req_valid = 4'b0100;
            req_sign[2] = s_tab[t];
            req_a[2*AW +: AW] = a_tab[t];
            req_b[2*BW +: BW] = b_tab[t];
            @(negedge clk);
            total++;
            if (req_ready !== 4'b0100) begin
                bad++;
                $display("FAIL single_ready[%0d]: got %b want 0100", t, req_ready);
            end
            tick();
            req_valid = '0;
            @(negedge clk);
            total++;
            if (rsp_valid !== 1'b0) begin
                bad++;
                $display("FAIL single_early[%0d]: rsp_valid got %b want 0", t, rsp_valid);
            end
            @(negedge clk);
            total++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_result !== e_tab[t]) begin
                bad++;
                $display("FAIL single_rsp[%0d]: got v=%b id=%0d res=%h want v=1 id=2 res=%h",
                         t, rsp_valid, rsp_id, rsp_result, e_tab[t]);
            end
        end
        tick();
    endtask

    task automatic test_round_robin();
        int exp_g;
        int g;
        int hits;
        exp_g = 3;
        rsp_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            req_valid = 4'b1111;
            rand_ops();
            @(negedge clk);
            g = -1; hits = 0;
            for (int r = 0; r < N; r++) if (req_ready[r]) begin g = r; hits++; end
            total++;
            if (hits != 1 || g != exp_g) begin
                bad++;
                $display("FAIL rr_order[%0d]: got %b want requester %0d", c, req_ready, exp_g);
            end
            exp_g = (exp_g + 1) % N;
            tick();
        end
        drain(6);
    endtask

    task automatic test_credit();
        int acc;
        acc = 0;
        rsp_ready = 1'b0;
        req_valid = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            rand_ops();
            @(negedge clk);
            acc += $countones(req_ready);
            tick();
        end
        total++;
        if (acc != DEPTH || req_ready !== 4'b0000) begin
            bad++;
            $display("FAIL credit_limit: got %0d accepts ready=%b want %0d accepts ready=0000", acc, req_ready, DEPTH);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        total++;
        if (req_ready !== 4'b0000 || rsp_valid !== 1'b1) begin
            bad++;
            $display("FAIL credit_same_cycle: got ready=%b rsp_valid=%b want 0000 and 1", req_ready, rsp_valid);
        end
        tick();
        rsp_ready = 1'b0;
        @(negedge clk);
        total++;
        if ($countones(req_ready) != 1) begin
            bad++;
            $display("FAIL credit_reuse: got ready=%b want one grant", req_ready);
        end
        tick();
        drain(10);
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            req_valid = N'($urandom);
            rand_ops();
            rsp_ready = (c < 150) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            tick();
        end
        drain(12);
    endtask

    task automatic test_reset_mid();
        rsp_ready = 1'b0;
        req_valid = 4'b1111;
        repeat (3) begin
            rand_ops();
            tick();
        end
        req_valid = '0;
        repeat (3) tick();
        @(negedge clk);
        total++;
        if (rsp_valid !== 1'b1) begin
            bad++;
            $display("FAIL mid_buffered: rsp_valid got %b want 1", rsp_valid);
        end
        tick();
        req_valid = 4'b1111;
        mon_en = 1'b0;
        rstn = 1'b0;
        #1;
        total++;
        if ({req_ready, mul_valid_o, rsp_valid, err, rsp_id, rsp_result} !== '0) begin
            bad++;
            $display("FAIL mid_reset_outputs: ready=%b mv=%b rv=%b err=%b id=%0d res=%h",
                     req_ready, mul_valid_o, rsp_valid, err, rsp_id, rsp_result);
        end
        repeat (2) tick();
        req_valid = '0;
        rstn = 1'b1;
        model_clear();
        mon_en = 1'b1;
        tick();
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        @(negedge clk);
        total++;
        if (req_ready !== 4'b0001) begin
            bad++;
            $display("FAIL mid_first_grant: got %b want 0001", req_ready);
        end
        tick();
        drain(6);
    endtask

    task automatic test_error();
        mon_en = 1'b0;
        rsp_ready = 1'b0;
        tick();
        inj = 1'b1;
        tick();
        inj = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            total++;
            if (err !== 1'b1) begin
                bad++;
                $display("FAIL err_sticky[%0d]: got %b want 1", c, err);
            end
            rsp_ready = (c == 2);
            tick();
        end
        rstn = 1'b0;
        #1;
        total++;
        if (err !== 1'b0) begin
            bad++;
            $display("FAIL err_reset: got %b want 0", err);
        end
        tick();
        rstn = 1'b1;
        model_clear();
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_credit();
        test_random();
        test_reset_mid();
        test_error();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
